// File: rtl/simt_alu_pipe.sv
// Multi-lane SIMT ALU: one opcode applied across LANES masked lanes,
// with a two-stage valid/ready pipeline (operand stage, result stage).
module simt_alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_opcode,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES-1:0]       out_zero,
    output logic                   out_all_zero,
    output logic [LANES-1:0]       out_mask,
    output logic                   out_illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_ADDS = 4'd10;
    localparam logic [3:0] OP_SUBS = 4'd11;
    localparam logic [3:0] OP_MIN  = 4'd12;
    localparam logic [3:0] OP_MAX  = 4'd13;

    logic                   s1_valid;
    logic [3:0]             s1_op;
    logic [LANES-1:0]       s1_mask;
    logic [LANES*WIDTH-1:0] s1_a;
    logic [LANES*WIDTH-1:0] s1_b;

    logic                   s2_valid;
    logic [LANES*WIDTH-1:0] s2_result;
    logic [LANES-1:0]       s2_zero;
    logic                   s2_all_zero;
    logic [LANES-1:0]       s2_mask;
    logic                   s2_illegal;

    logic                   s1_free;
    logic                   s2_free;
    logic [WIDTH-1:0]       lane;
    logic [LANES*WIDTH-1:0] alu_res;
    logic [LANES-1:0]       alu_zero;
    logic                   alu_all_zero;
    logic                   alu_illegal;

    // Single-lane operation; undefined opcodes produce 0.
    function automatic logic [WIDTH-1:0] lane_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   dif;
        logic [SHW-1:0]   sh;
        logic             lt_s;
        logic [WIDTH-1:0] smax;
        logic [WIDTH-1:0] smin;
        logic [WIDTH-1:0] r;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        sum  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        dif  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        sh   = b[SHW-1:0];
        lt_s = $signed(a) < $signed(b);
        r    = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = WIDTH'($signed(a) >>> sh);
            // Overflow shows as disagreement between the two top bits of the
            // extended result; the extension bit carries the true sign.
            OP_ADDS: r = (sum[WIDTH] != sum[WIDTH-1]) ? (sum[WIDTH] ? smin : smax)
                                                      : sum[WIDTH-1:0];
            OP_SUBS: r = (dif[WIDTH] != dif[WIDTH-1]) ? (dif[WIDTH] ? smin : smax)
                                                      : dif[WIDTH-1:0];
            OP_MIN:  r = lt_s ? a : b;
            OP_MAX:  r = lt_s ? b : a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign s2_free  = !s2_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free;

    // Per-lane compute with mask gating and zero flags.
    always_comb begin
        lane         = '0;
        alu_res      = '0;
        alu_zero     = '0;
        alu_illegal  = (s1_op > OP_MAX);
        for (int i = 0; i < LANES; i++) begin
            lane = lane_op(s1_op, s1_a[i*WIDTH +: WIDTH], s1_b[i*WIDTH +: WIDTH]);
            if (!s1_mask[i]) begin
                lane = '0;
            end
            alu_res[i*WIDTH +: WIDTH] = lane;
            alu_zero[i]               = s1_mask[i] && (lane == '0);
        end
        alu_all_zero = &(alu_zero | ~s1_mask);
    end

    // Operand stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_mask  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= in_opcode;
                s1_mask <= in_mask;
                s1_a    <= in_a;
                s1_b    <= in_b;
            end
        end
    end

    // Result stage; drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_result   <= '0;
            s2_zero     <= '0;
            s2_all_zero <= 1'b0;
            s2_mask     <= '0;
            s2_illegal  <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result   <= alu_res;
                s2_zero     <= alu_zero;
                s2_all_zero <= alu_all_zero;
                s2_mask     <= s1_mask;
                s2_illegal  <= alu_illegal;
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_result   = s2_result;
    assign out_zero     = s2_zero;
    assign out_all_zero = s2_all_zero;
    assign out_mask     = s2_mask;
    assign out_illegal  = s2_illegal;

endmodule
